spi_slave_reg_frame: RTL and testbench

- Oversampled SPI slave frame engine for the control channel; converts SPI register frames into single-cycle register-bus strobes in the system clock domain.
- Frame format: 1 command byte, ADDR_BYTES address bytes, then DATA_BYTES data bytes.
- Generalises the fixed 5-byte control frame with:
  - parametrised address/data widths, bit order, CS polarity and command codes;
  - command-error and abort reporting;
  - a read-data latency window.
- Sits between the SPI pads and the control register file.

---
 rtl/spi_frame_pkg.sv | 23 ++
 rtl/spi_in_sync.sv | 77 +++++++
 rtl/spi_slave_reg_frame.sv | 238 +++++++++++++++++++++++
 tb/tb_spi_slave_reg_frame.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI register-frame slave.
//   state_e     : frame engine states
//   CMD_*_DEF   : default command codes
//   frame_bits  : total bit count of one frame (command + address + data)
package spi_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DONE,
        IGNORE
    } state_e;

    localparam logic [7:0] CMD_WR_DEF = 8'h80;
    localparam logic [7:0] CMD_RD_DEF = 8'h81;

    function automatic int frame_bits(input int addr_bytes, input int data_bytes);
        return 8 * (1 + addr_bytes + data_bytes);
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchronisers for the SPI pins plus edge detection.
//   clk, rst_n          : system clock, async active-low reset
//   i_sck/i_cs/i_mosi   : raw SPI pins
//   sck_rise/sck_fall   : one-clk pulses on synchronised SCK edges
//   cs_rise/cs_fall     : one-clk pulses on the active-level-normalised CS
//   mosi                : MOSI sample aligned with the sck_rise pulse
// A pin edge reaches its pulse output 3 clk later.
module spi_in_sync #(
    parameter bit CS_ACT_HIGH = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sck,
    input  logic i_cs,
    input  logic i_mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_rise,
    output logic cs_fall,
    output logic mosi
);

    // CS is normalised before synchronising so that reset (all zeros)
    // means "not selected" for either polarity.
    logic cs_norm;
    assign cs_norm = CS_ACT_HIGH ? i_cs : ~i_cs;

    logic [2:0] sck_sh_q, sck_sh_d;
    logic [2:0] cs_sh_q,  cs_sh_d;
    logic [1:0] mosi_sh_q, mosi_sh_d;
    logic sck_rise_q, sck_rise_d;
    logic sck_fall_q, sck_fall_d;
    logic cs_rise_q,  cs_rise_d;
    logic cs_fall_q,  cs_fall_d;
    logic mosi_q,     mosi_d;

    always_comb begin
        sck_sh_d   = {sck_sh_q[1:0], i_sck};
        cs_sh_d    = {cs_sh_q[1:0], cs_norm};
        mosi_sh_d  = {mosi_sh_q[0], i_mosi};
        sck_rise_d =  sck_sh_q[1] & ~sck_sh_q[2];
        sck_fall_d = ~sck_sh_q[1] &  sck_sh_q[2];
        cs_rise_d  =  cs_sh_q[1]  & ~cs_sh_q[2];
        cs_fall_d  = ~cs_sh_q[1]  &  cs_sh_q[2];
        // MOSI taken from the same synchroniser depth as the SCK edge
        mosi_d     = mosi_sh_q[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sh_q   <= '0;
            cs_sh_q    <= '0;
            mosi_sh_q  <= '0;
            sck_rise_q <= 1'b0;
            sck_fall_q <= 1'b0;
            cs_rise_q  <= 1'b0;
            cs_fall_q  <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            sck_sh_q   <= sck_sh_d;
            cs_sh_q    <= cs_sh_d;
            mosi_sh_q  <= mosi_sh_d;
            sck_rise_q <= sck_rise_d;
            sck_fall_q <= sck_fall_d;
            cs_rise_q  <= cs_rise_d;
            cs_fall_q  <= cs_fall_d;
            mosi_q     <= mosi_d;
        end
    end

    assign sck_rise = sck_rise_q;
    assign sck_fall = sck_fall_q;
    assign cs_rise  = cs_rise_q;
    assign cs_fall  = cs_fall_q;
    assign mosi     = mosi_q;

endmodule

// File: rtl/spi_slave_reg_frame.sv
// Oversampled SPI slave that turns register frames
// (command, ADDR_BYTES address, DATA_BYTES data) into one-clk register-bus
// strobes in the system clock domain.
//   clk_osc_bufg, reset_osc_bufg_n : system clock (>= 8x SCK), async active-low reset
//   i_spi_clk/cs/mosi, o_spi_miso/_oe : SPI pins
//   o_wr_en, ov_addr, ov_wr_data   : write strobe with address/data
//   o_rd_en, iv_rd_data            : read request; data valid RD_LATENCY clk later
//   o_cmd_err, o_frame_abort       : error pulses
//   o_busy                         : frame in progress
module spi_slave_reg_frame
    import spi_frame_pkg::*;
#(
    parameter string      SPI_FIRST_DATA = "MSB",
    parameter string      SPI_CS_POL     = "LOW",
    parameter int         ADDR_BYTES     = 2,
    parameter int         DATA_BYTES     = 2,
    parameter logic [7:0] CMD_WR         = CMD_WR_DEF,
    parameter logic [7:0] CMD_RD         = CMD_RD_DEF,
    parameter int         RD_LATENCY     = 2
) (
    input  logic                    clk_osc_bufg,
    input  logic                    reset_osc_bufg_n,
    input  logic                    i_spi_clk,
    input  logic                    i_spi_cs,
    input  logic                    i_spi_mosi,
    output logic                    o_spi_miso,
    output logic                    o_spi_miso_oe,
    output logic                    o_wr_en,
    output logic                    o_rd_en,
    output logic [8*ADDR_BYTES-1:0] ov_addr,
    output logic [8*DATA_BYTES-1:0] ov_wr_data,
    input  logic [8*DATA_BYTES-1:0] iv_rd_data,
    output logic                    o_cmd_err,
    output logic                    o_frame_abort,
    output logic                    o_busy
);

    localparam int AW        = 8 * ADDR_BYTES;
    localparam int DW        = 8 * DATA_BYTES;
    localparam int ACC_W     = (AW > DW) ? AW : DW;
    localparam int FB        = frame_bits(ADDR_BYTES, DATA_BYTES);
    localparam int CW        = $clog2(FB + 1);
    localparam bit LSB_FIRST = (SPI_FIRST_DATA == "LSB");
    localparam bit CS_HIGH   = (SPI_CS_POL == "HIGH");
    localparam logic [CW-1:0] ADDR_LAST = CW'(8 * (1 + ADDR_BYTES) - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(FB - 1);

    logic sck_rise, sck_fall, cs_rise, cs_fall, mosi;

    spi_in_sync #(.CS_ACT_HIGH(CS_HIGH)) u_sync (
        .clk      (clk_osc_bufg),
        .rst_n    (reset_osc_bufg_n),
        .i_sck    (i_spi_clk),
        .i_cs     (i_spi_cs),
        .i_mosi   (i_spi_mosi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_rise  (cs_rise),
        .cs_fall  (cs_fall),
        .mosi     (mosi)
    );

    state_e                state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]            byte_q, byte_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic                  is_rd_q, is_rd_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DW-1:0]         wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic                  cmd_err_q, cmd_err_d;
    logic                  abort_q, abort_d;
    logic                  busy_q, busy_d;
    logic [RD_LATENCY-1:0] rd_dly_q, rd_dly_d;
    logic [DW-1:0]         tx_q, tx_d;
    logic                  miso_q, miso_d;
    logic                  oe_q, oe_d;

    logic [7:0]       byte_nx;
    logic [ACC_W-1:0] acc_nx;
    logic [DW-1:0]    rd_tx;
    logic             byte_end;

    always_comb begin
        byte_nx  = LSB_FIRST ? {mosi, byte_q[7:1]} : {byte_q[6:0], mosi};
        // completed bytes enter at the bottom; fields are MS byte first
        acc_nx   = (acc_q << 8) | ACC_W'(byte_nx);
        byte_end = (bit_cnt_q[2:0] == 3'd7);

        // Transmit vector is always shifted out from the top bit, so for
        // LSB-first each byte is bit-reversed on capture.
        rd_tx = '0;
        for (int b = 0; b < DATA_BYTES; b++) begin
            for (int i = 0; i < 8; i++) begin
                rd_tx[8*b+i] = LSB_FIRST ? iv_rd_data[8*b+7-i] : iv_rd_data[8*b+i];
            end
        end

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        byte_d    = byte_q;
        acc_d     = acc_q;
        is_rd_d   = is_rd_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        cmd_err_d = 1'b0;
        abort_d   = 1'b0;
        rd_dly_d  = RD_LATENCY'({rd_dly_q, rd_en_q});
        tx_d      = tx_q;
        miso_d    = miso_q;
        oe_d      = oe_q;

        if (rd_dly_q[RD_LATENCY-1]) tx_d = rd_tx;

        if (cs_fall) begin
            // CS wins over any SCK edge in the same clk
            if (state_q inside {CMD, ADDR, DATA}) abort_d = 1'b1;
            state_d = IDLE;
            miso_d  = 1'b0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_rise) begin
                        state_d   = CMD;
                        bit_cnt_d = '0;
                        byte_d    = '0;
                        acc_d     = '0;
                        is_rd_d   = 1'b0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        byte_d    = byte_nx;
                        if (byte_end) begin
                            if (byte_nx == CMD_WR || byte_nx == CMD_RD) begin
                                state_d = ADDR;
                                is_rd_d = (byte_nx == CMD_RD);
                            end else begin
                                state_d   = IGNORE;
                                cmd_err_d = 1'b1;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        byte_d    = byte_nx;
                        if (byte_end) acc_d = acc_nx;
                        if (bit_cnt_q == ADDR_LAST) begin
                            state_d = DATA;
                            addr_d  = acc_nx[AW-1:0];
                            rd_en_d = is_rd_q;
                        end
                    end
                end
                DATA: begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        byte_d    = byte_nx;
                        if (byte_end) acc_d = acc_nx;
                        if (bit_cnt_q == DATA_LAST) begin
                            state_d = DONE;
                            if (!is_rd_q) begin
                                wr_data_d = acc_nx[DW-1:0];
                                wr_en_d   = 1'b1;
                            end
                        end
                    end
                    // read bits leave on falling SCK; the fall after the
                    // last data bit already lands in DONE and is ignored
                    if (sck_fall && is_rd_q) begin
                        miso_d = tx_q[DW-1];
                        tx_d   = tx_q << 1;
                        oe_d   = 1'b1;
                    end
                end
                default: ;  // DONE / IGNORE wait for CS release
            endcase
        end

        busy_d = (state_d inside {CMD, ADDR, DATA});
    end

    always_ff @(posedge clk_osc_bufg or negedge reset_osc_bufg_n) begin
        if (!reset_osc_bufg_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            byte_q    <= '0;
            acc_q     <= '0;
            is_rd_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            cmd_err_q <= 1'b0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b0;
            rd_dly_q  <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            byte_q    <= byte_d;
            acc_q     <= acc_d;
            is_rd_q   <= is_rd_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            cmd_err_q <= cmd_err_d;
            abort_q   <= abort_d;
            busy_q    <= busy_d;
            rd_dly_q  <= rd_dly_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
        end
    end

    assign o_spi_miso    = miso_q;
    assign o_spi_miso_oe = oe_q;
    assign o_wr_en       = wr_en_q;
    assign o_rd_en       = rd_en_q;
    assign ov_addr       = addr_q;
    assign ov_wr_data    = wr_data_q;
    assign o_cmd_err     = cmd_err_q;
    assign o_frame_abort = abort_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_reg_frame.sv
// Directed bench: dut0 is the default 2/2-byte MSB-first, CS-low slave
// (RD_LATENCY 2); dut1 is 1/4-byte LSB-first, CS-high (RD_LATENCY 3).
// SCK and MOSI are shared; only one CS is active at a time.
module tb_spi_slave_reg_frame;

    localparam int HS = 200;  // SCK half period = 20 clk (clk period 10)

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck = 1'b0, mosi = 1'b0, cs0 = 1'b1, cs1 = 1'b0;

    logic        miso0, oe0, wr0, rd0, err0, abt0, busy0;
    logic [15:0] addr0, wdat0, rdat0;
    logic        miso1, oe1, wr1, rd1, err1, abt1, busy1;
    logic [7:0]  addr1;
    logic [31:0] wdat1, rdat1;

    always #5 clk = ~clk;

    spi_slave_reg_frame dut0 (
        .clk_osc_bufg(clk), .reset_osc_bufg_n(rst_n),
        .i_spi_clk(sck), .i_spi_cs(cs0), .i_spi_mosi(mosi),
        .o_spi_miso(miso0), .o_spi_miso_oe(oe0),
        .o_wr_en(wr0), .o_rd_en(rd0), .ov_addr(addr0), .ov_wr_data(wdat0),
        .iv_rd_data(rdat0), .o_cmd_err(err0), .o_frame_abort(abt0), .o_busy(busy0)
    );

    spi_slave_reg_frame #(
        .SPI_FIRST_DATA("LSB"), .SPI_CS_POL("HIGH"),
        .ADDR_BYTES(1), .DATA_BYTES(4), .RD_LATENCY(3)
    ) dut1 (
        .clk_osc_bufg(clk), .reset_osc_bufg_n(rst_n),
        .i_spi_clk(sck), .i_spi_cs(cs1), .i_spi_mosi(mosi),
        .o_spi_miso(miso1), .o_spi_miso_oe(oe1),
        .o_wr_en(wr1), .o_rd_en(rd1), .ov_addr(addr1), .ov_wr_data(wdat1),
        .iv_rd_data(rdat1), .o_cmd_err(err1), .o_frame_abort(abt1), .o_busy(busy1)
    );

    // register-file model: read data valid only in the latency slot
    logic [15:0] rd_val0 = 16'h0;
    logic [31:0] rd_val1 = 32'h0;
    logic [3:0]  rp0 = 4'h0, rp1 = 4'h0;
    always @(posedge clk) begin
        rp0 <= {rp0[2:0], rd0};
        rp1 <= {rp1[2:0], rd1};
    end
    assign rdat0 = rp0[1] ? rd_val0 : 16'h0F0F;
    assign rdat1 = rp1[2] ? rd_val1 : 32'h0F0F_0F0F;

    // strobe monitors; a wide pulse counts more than once
    int wr_n0 = 0, rd_n0 = 0, err_n0 = 0, abt_n0 = 0, bad_miso0 = 0;
    int wr_n1 = 0, rd_n1 = 0;
    logic [15:0] wa0 = 16'h0, wd0 = 16'h0;
    logic [7:0]  wa1 = 8'h0;
    logic [31:0] wd1 = 32'h0;
    always @(negedge clk) begin
        if (wr0) begin wr_n0++; wa0 = addr0; wd0 = wdat0; end
        if (rd0) rd_n0++;
        if (err0) err_n0++;
        if (abt0) abt_n0++;
        if (miso0 && !oe0) bad_miso0++;
        if (wr1) begin wr_n1++; wa1 = addr1; wd1 = wdat1; end
        if (rd1) rd_n1++;
    end

    int errs = 0, nchk = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] txb [16];
    logic [7:0] rxb [16];
    int oe_pre, oe_dat;

    task automatic set5(input logic [7:0] a, b, c, d, e);
        txb[0] = a; txb[1] = b; txb[2] = c; txb[3] = d; txb[4] = e;
    endtask

    // Mode-0 master: sends nbits of txb, samples MISO/OE on each rising SCK.
    task automatic spi_frame(input int sel, input int nbits, input int dstart,
                             input bit lsb, input int extra, input bit keep_cs);
        logic oe;
        @(negedge clk); #2;
        if (sel == 0) cs0 = 1'b0; else cs1 = 1'b1;
        oe_pre = 0; oe_dat = 0;
        #HS;
        for (int k = 0; k < nbits; k++) begin
            int b, p;
            b = k / 8;
            p = lsb ? (k % 8) : (7 - (k % 8));
            mosi = txb[b][p];
            #HS;
            if (sel == 0) begin rxb[b][p] = miso0; oe = oe0; end
            else          begin rxb[b][p] = miso1; oe = oe1; end
            if (k < dstart) oe_pre += int'(oe); else oe_dat += int'(oe);
            sck = 1'b1; #HS; sck = 1'b0;
        end
        for (int k = 0; k < extra; k++) begin
            mosi = 1'b1; #HS; sck = 1'b1; #HS; sck = 1'b0;
        end
        #HS;
        mosi = 1'b0;
        if (!keep_cs) begin cs0 = 1'b1; cs1 = 1'b0; #HS; end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst strobes", {wr0, rd0, err0, abt0, busy0, miso0, oe0}, 0);
        chk("rst addr/data", {addr0, wdat0}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post-rst outs", {wr0, rd0, err0, abt0, busy0, miso0, oe0, wr1, busy1}, 0);

        // plain write
        set5(8'h80, 8'h00, 8'h55, 8'hAB, 8'h56);
        spi_frame(0, 40, 24, 1'b0, 0, 1'b0);
        chk("wr count", wr_n0, 1);
        chk("wr addr", wa0, 16'h0055);
        chk("wr data", wd0, 16'hAB56);
        chk("ov held", {addr0, wdat0}, 32'h0055_AB56);
        chk("wr no rd/abt", {rd_n0[7:0], abt_n0[7:0]}, 0);

        // read: data only valid in the RD_LATENCY slot
        rd_val0 = 16'hAB56;
        set5(8'h81, 8'h00, 8'h55, 8'h00, 8'h00);
        spi_frame(0, 40, 24, 1'b0, 0, 1'b0);
        chk("rd count", rd_n0, 1);
        chk("rd no wr", wr_n0, 1);
        chk("rd miso", {rxb[3], rxb[4]}, 16'hAB56);
        chk("rd oe pre", oe_pre, 0);
        chk("rd oe data", oe_dat, 16);
        chk("rd oe after cs", {oe0, miso0}, 0);
        chk("busy idle", busy0, 0);

        // unknown command, then a good frame
        set5(8'h82, 8'h00, 8'h40, 8'h48, 8'h21);
        spi_frame(0, 40, 24, 1'b0, 0, 1'b0);
        chk("cmd err count", err_n0, 1);
        chk("cmd err no strobe", {wr_n0[7:0], rd_n0[7:0]}, 16'h0101);
        set5(8'h80, 8'h01, 8'h64, 8'h74, 8'h88);
        spi_frame(0, 40, 24, 1'b0, 0, 1'b0);
        chk("after err wr", wr_n0, 2);
        chk("after err addr/data", {wa0, wd0}, 32'h0164_7488);

        // abort after 3 bytes, then recovery
        set5(8'h80, 8'h00, 8'hB4, 8'hD8, 8'h36);
        spi_frame(0, 24, 24, 1'b0, 0, 1'b0);
        chk("abort count", abt_n0, 1);
        chk("abort no wr", wr_n0, 2);
        spi_frame(0, 40, 24, 1'b0, 0, 1'b0);
        chk("post-abort wr", wr_n0, 3);
        chk("post-abort addr/data", {wa0, wd0}, 32'h00B4_D836);
        chk("post-abort no abt", abt_n0, 1);

        // back-to-back with trailing SCK and a 10-SCK gap
        set5(8'h80, 8'h12, 8'h34, 8'h56, 8'h78);
        spi_frame(0, 40, 24, 1'b0, 6, 1'b0);
        chk("b2b wr 1", wr_n0, 4);
        chk("b2b data 1", {wa0, wd0}, 32'h1234_5678);
        #(20 * HS);
        set5(8'h80, 8'h9A, 8'hBC, 8'hDE, 8'hF0);
        spi_frame(0, 40, 24, 1'b0, 6, 1'b0);
        chk("b2b wr 2", wr_n0, 5);
        chk("b2b data 2", {wa0, wd0}, 32'h9ABC_DEF0);

        // reset in the middle of the address phase
        set5(8'h80, 8'h00, 8'h21, 8'hCA, 8'hFE);
        spi_frame(0, 12, 24, 1'b0, 0, 1'b1);
        chk("mid-addr busy", busy0, 1);
        rst_n = 1'b0;
        #1;
        chk("mid rst outs", {wr0, rd0, err0, abt0, busy0, miso0, oe0}, 0);
        chk("mid rst addr/data", {addr0, wdat0}, 0);
        cs0 = 1'b1;
        #(4 * HS);
        @(negedge clk); rst_n = 1'b1;
        #HS;
        spi_frame(0, 40, 24, 1'b0, 0, 1'b0);
        chk("post-rst wr", wr_n0, 6);
        chk("post-rst addr/data", {wa0, wd0}, 32'h0021_CAFE);
        chk("no stray miso", bad_miso0, 0);

        // second configuration: 1 addr byte, 4 data bytes, LSB first, CS high
        txb[0] = 8'h80; txb[1] = 8'h12; txb[2] = 8'hDE;
        txb[3] = 8'hAD; txb[4] = 8'hBE; txb[5] = 8'hEF;
        spi_frame(1, 48, 16, 1'b1, 0, 1'b0);
        chk("cfg1 wr count", wr_n1, 1);
        chk("cfg1 addr", wa1, 8'h12);
        chk("cfg1 data", wd1, 32'hDEADBEEF);
        chk("cfg1 dut0 quiet", wr_n0, 6);

        rd_val1 = 32'h1234_5678;
        txb[0] = 8'h81; txb[1] = 8'h12; txb[2] = 8'h00;
        txb[3] = 8'h00; txb[4] = 8'h00; txb[5] = 8'h00;
        spi_frame(1, 48, 16, 1'b1, 0, 1'b0);
        chk("cfg1 rd count", rd_n1, 1);
        chk("cfg1 rd miso", {rxb[2], rxb[3], rxb[4], rxb[5]}, 32'h1234_5678);
        chk("cfg1 oe", {oe_pre[7:0], oe_dat[7:0]}, 16'h0020);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
